serial_frame_deser: RTL and testbench



---
 rtl/serial_frame_deser.sv | 108 ++++++++++
 tb/tb_serial_frame_deser.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deser.sv
// Serial-to-parallel frame receiver: start=1, WIDTH data bits MSB-first, optional even parity, stop=0.
// Define SERIAL_DESER_PARITY_EN to compile in the parity bit check.
module serial_frame_deser #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CW = $clog2(WIDTH);

`ifdef SERIAL_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             ovr_q;
    logic             par_ok;
    logic             good_d;

`ifdef SERIAL_DESER_PARITY_EN
    logic             par_q;
    always_comb par_ok = ~(^shift_q ^ par_q);
`else
    always_comb par_ok = 1'b1;
`endif

    always_comb begin
        shift_d = {shift_q[WIDTH-2:0], serial_in};
        good_d  = ~serial_in & par_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && data_ready) valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (serial_in) state_q <= DATA;
                end
                DATA: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERIAL_DESER_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                PARITY: begin
                    par_q   <= serial_in;
                    state_q <= STOP;
                end
`endif
                STOP: begin
                    state_q <= IDLE;
                    if (!good_d) begin
                        ferr_q <= 1'b1;
                    end else if (!valid_q || data_ready) begin
                        // A load on the consuming edge overrides the handshake clear above.
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                    end else begin
                        ovr_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
// Table-driven bench for serial_frame_deser (WIDTH=4); per-cycle vectors with hand-computed outputs.
module tb_serial_frame_deser;

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic       data_ready;
    logic [3:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       si;
        logic       rdy;
        logic       v;
        logic [3:0] d;
        logic       fe;
        logic       ov;
    } vec_t;

    vec_t tbl[$];

    serial_frame_deser #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic vec(input logic r, input logic si, input logic rdy,
                       input logic v, input logic [3:0] d, input logic fe, input logic ov);
        vec_t e;
        e.rst = r; e.si = si; e.rdy = rdy; e.v = v; e.d = d; e.fe = fe; e.ov = ov;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; serial_in = 1'b0; data_ready = 1'b0;

`ifdef SERIAL_DESER_PARITY_EN
        vec(0,0,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);   // start, data 1001, parity 1 (bad), stop 0
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,1,0);
        vec(1,1,0, 0,4'h0,0,0);   // start, data 1001, parity 0 (good), stop 0
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,0,0, 1,4'h9,0,0);
        vec(1,0,1, 0,4'h9,0,0);
`else
        vec(0,0,0, 0,4'h0,0,0);
        // good frame 1011
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,0,0, 1,4'hB,0,0);
        vec(1,0,1, 0,4'hB,0,0);
        // bad stop, then stop-slot 1 must not count as a start bit
        vec(1,1,0, 0,4'hB,0,0);
        vec(1,0,0, 0,4'hB,0,0);
        vec(1,1,0, 0,4'hB,0,0);
        vec(1,0,0, 0,4'hB,0,0);
        vec(1,1,0, 0,4'hB,0,0);
        vec(1,1,0, 0,4'hB,1,0);
        vec(1,1,0, 0,4'hB,0,0);
        vec(1,0,0, 0,4'hB,0,0);
        vec(1,0,0, 0,4'hB,0,0);
        vec(1,1,0, 0,4'hB,0,0);
        vec(1,1,0, 0,4'hB,0,0);
        vec(1,0,0, 1,4'h3,0,0);
        vec(1,0,1, 0,4'h3,0,0);
        // overrun: A, then 5 dropped, then C loads on consuming edge
        vec(1,1,0, 0,4'h3,0,0);
        vec(1,1,0, 0,4'h3,0,0);
        vec(1,0,0, 0,4'h3,0,0);
        vec(1,1,0, 0,4'h3,0,0);
        vec(1,0,0, 0,4'h3,0,0);
        vec(1,0,0, 1,4'hA,0,0);
        vec(1,1,0, 1,4'hA,0,0);
        vec(1,0,0, 1,4'hA,0,0);
        vec(1,1,0, 1,4'hA,0,0);
        vec(1,0,0, 1,4'hA,0,0);
        vec(1,1,0, 1,4'hA,0,0);
        vec(1,0,0, 1,4'hA,0,1);
        vec(1,1,0, 1,4'hA,0,0);
        vec(1,1,0, 1,4'hA,0,0);
        vec(1,1,0, 1,4'hA,0,0);
        vec(1,0,0, 1,4'hA,0,0);
        vec(1,0,0, 1,4'hA,0,0);
        vec(1,0,1, 1,4'hC,0,0);
        vec(1,0,1, 0,4'hC,0,0);
        // back-to-back F and 1, ready held high
        vec(1,1,1, 0,4'hC,0,0);
        vec(1,1,1, 0,4'hC,0,0);
        vec(1,1,1, 0,4'hC,0,0);
        vec(1,1,1, 0,4'hC,0,0);
        vec(1,1,1, 0,4'hC,0,0);
        vec(1,0,1, 1,4'hF,0,0);
        vec(1,0,1, 0,4'hF,0,0);
        vec(1,1,1, 0,4'hF,0,0);
        vec(1,0,1, 0,4'hF,0,0);
        vec(1,0,1, 0,4'hF,0,0);
        vec(1,0,1, 0,4'hF,0,0);
        vec(1,1,1, 0,4'hF,0,0);
        vec(1,0,1, 1,4'h1,0,0);
        vec(1,0,0, 1,4'h1,0,0);
        // reset after two data bits, then fresh frame 0110
        vec(1,1,0, 1,4'h1,0,0);
        vec(1,0,0, 1,4'h1,0,0);
        vec(1,1,0, 1,4'h1,0,0);
        vec(0,1,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,1,0, 0,4'h0,0,0);
        vec(1,0,0, 0,4'h0,0,0);
        vec(1,0,0, 1,4'h6,0,0);
`endif

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n = tbl[i].rst; serial_in = tbl[i].si; data_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk("data_valid", i, {3'b0, data_valid}, {3'b0, tbl[i].v});
            chk("data_out",   i, data_out,           tbl[i].d);
            chk("frame_err",  i, {3'b0, frame_err},  {3'b0, tbl[i].fe});
            chk("overrun",    i, {3'b0, overrun},    {3'b0, tbl[i].ov});
        end

        // Reset must clear outputs asynchronously, without waiting for a clock edge.
        @(negedge clk);
        data_ready = 1'b0; serial_in = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", -1, {3'b0, data_valid}, 4'h0);
        chk("async_rst_data",  -1, data_out, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
